// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit with valid/ready handshakes and an OR/AND/XOR accumulator.
// Optional out_zero/out_parity flag outputs are enabled with `define LOGIC_UNIT_PIPE_FLAGS_EN.
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] result;
  logic             xfer_in;
  logic             xfer_out;

  assign in_ready = ~out_valid | out_ready;
  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  // A clear together with an accumulate beat restarts the reduction from this word.
  always_comb begin
    b_eff  = in2;
    result = '0;
    if (acc_mode) begin
      b_eff = acc_clr ? '0 : acc;
    end
    case (op)
      3'b000:  result = in1 & b_eff;
      3'b001:  result = in1 | b_eff;
      3'b010:  result = in1 ^ b_eff;
      3'b011:  result = ~(in1 & b_eff);
      3'b100:  result = ~(in1 | b_eff);
      3'b101:  result = ~(in1 ^ b_eff);
      3'b110:  result = ~in1;
      default: result = in1;
    endcase
  end

  // An accepted accumulate beat wins over a standalone clear; the held result is replaced on any accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (xfer_in && acc_mode) begin
        acc <= result;
      end else if (acc_clr) begin
        acc <= '0;
      end
      if (xfer_in) begin
        out       <= result;
        out_valid <= 1'b1;
      end else if (xfer_out) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero   <= 1'b1;
      out_parity <= 1'b0;
    end else if (xfer_in) begin
      out_zero   <= (result == '0);
      out_parity <= ^result;
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: table-driven beats plus hand-written backpressure,
// clear and reset sequences, with a scoreboard queue compared as results are consumed.
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic       acc_mode;
  logic       acc_clr;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
  logic       out_zero;
  logic       out_parity;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] expq[$];

  typedef struct {
    logic [2:0] op;
    logic       am;
    logic       ac;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .acc_mode  (acc_mode),
    .acc_clr   (acc_clr),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [2:0] o, input logic am, input logic ac,
                        input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    vec_t v;
    v.op = o; v.am = am; v.ac = ac; v.a = a; v.b = b; v.exp = e;
    vecs.push_back(v);
  endtask

  // Holds the beat until accepted, pushing its expected result at the moment it is accepted.
  task automatic applyStimulus(input logic [2:0] o, input logic am, input logic ac,
                               input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    bit done;
    done = 1'b0;
    @(negedge clk);
    op = o; acc_mode = am; acc_clr = ac; in1 = a; in2 = b; in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      if (in_ready) begin
        expq.push_back(e);
        done = 1'b1;
        @(posedge clk);
      end else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      acc_clr  = 1'b0;
    end
  endtask

  // Scoreboard: every consumed result is compared against the oldest expected value.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_beat: got out=0x%0h, expected no beat", out);
      end else begin
        logic [7:0] e;
        e = expq.pop_front();
        checkOutput("out", {24'h0, out}, {24'h0, e});
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
        checkOutput("out_zero", {31'h0, out_zero}, {31'h0, (e == 8'h00)});
        checkOutput("out_parity", {31'h0, out_parity}, {31'h0, ^e});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'b000; acc_mode = 1'b0; acc_clr = 1'b0; in1 = 8'h00; in2 = 8'h00;

    addVec(3'b000, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'h05);
    addVec(3'b001, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'hAF);
    addVec(3'b010, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'hAA);
    addVec(3'b011, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'hFA);
    addVec(3'b100, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'h50);
    addVec(3'b101, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'h55);
    addVec(3'b110, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'h5A);
    addVec(3'b111, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'hA5);
    addVec(3'b011, 1'b0, 1'b0, 8'hF0, 8'hFF, 8'h0F);
    addVec(3'b101, 1'b0, 1'b0, 8'hFF, 8'h0F, 8'h0F);
    addVec(3'b110, 1'b0, 1'b0, 8'h3C, 8'h00, 8'hC3);
    addVec(3'b010, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h00);
    addVec(3'b111, 1'b0, 1'b0, 8'h07, 8'hFF, 8'h07);
    addVec(3'b001, 1'b1, 1'b1, 8'h01, 8'hFF, 8'h01);
    addVec(3'b001, 1'b1, 1'b0, 8'h10, 8'hFF, 8'h11);
    addVec(3'b001, 1'b1, 1'b0, 8'h80, 8'h00, 8'h91);
    addVec(3'b010, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h6E);
    addVec(3'b111, 1'b1, 1'b0, 8'h33, 8'h00, 8'h33);
    addVec(3'b000, 1'b1, 1'b0, 8'hF0, 8'hFF, 8'h30);

    #3;
    checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_out", {24'h0, out}, 32'h0);
    checkOutput("reset_in_ready", {31'h0, in_ready}, 32'h1);
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
    checkOutput("reset_out_zero", {31'h0, out_zero}, 32'h1);
    checkOutput("reset_out_parity", {31'h0, out_parity}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].am, vecs[i].ac, vecs[i].a, vecs[i].b, vecs[i].exp);
    end
    idle(3);

    // Backpressure: 0x11 is held while 0x22 waits, then both transfer on the same edge.
    @(negedge clk);
    out_ready = 1'b0; op = 3'b111; acc_mode = 1'b0; acc_clr = 1'b0; in1 = 8'h11; in2 = 8'h00;
    in_valid = 1'b1;
    #1;
    checkOutput("bp_first_ready", {31'h0, in_ready}, 32'h1);
    expq.push_back(8'h11);
    @(posedge clk);
    @(negedge clk);
    in1 = 8'h22;
    for (int k = 0; k < 5; k++) begin
      #3;
      checkOutput("bp_in_ready", {31'h0, in_ready}, 32'h0);
      checkOutput("bp_out_hold", {24'h0, out}, 32'h11);
      checkOutput("bp_out_valid", {31'h0, out_valid}, 32'h1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'h0, in_ready}, 32'h1);
    expq.push_back(8'h22);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("bp_no_bubble_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("bp_no_bubble_out", {24'h0, out}, 32'h22);
    idle(2);

    // Clear pulse with no beat must zero the accumulator.
    applyStimulus(3'b001, 1'b1, 1'b1, 8'h01, 8'h00, 8'h01);
    applyStimulus(3'b001, 1'b1, 1'b0, 8'h10, 8'h00, 8'h11);
    applyStimulus(3'b001, 1'b1, 1'b0, 8'h80, 8'h00, 8'h91);
    @(negedge clk);
    in_valid = 1'b0; acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    applyStimulus(3'b001, 1'b1, 1'b0, 8'h04, 8'h00, 8'h04);
    idle(2);

    // Asynchronous reset while a result is held and acc is 0x91.
    applyStimulus(3'b001, 1'b1, 1'b1, 8'h01, 8'h00, 8'h01);
    applyStimulus(3'b001, 1'b1, 1'b0, 8'h10, 8'h00, 8'h11);
    applyStimulus(3'b001, 1'b1, 1'b0, 8'h80, 8'h00, 8'h91);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_mid_out", {24'h0, out}, 32'h0);
    checkOutput("rst_mid_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_after_no_beat", {31'h0, out_valid}, 32'h0);
    applyStimulus(3'b001, 1'b1, 1'b0, 8'h02, 8'h00, 8'h02);
    idle(4);

    checkOutput("scoreboard_drained", expq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered bitwise logic unit: the successor to the fixed 8-bit two-input gate arrays. One op-select input selects any of eight bitwise functions over `WIDTH`-bit operands. The result sits in a single pipeline register with valid/ready handshakes on both sides. An accumulator mode folds a stream of words into a running result (OR/AND/XOR reductions). It sits between a producer and a consumer in the datapath and replaces per-function gate-array instances.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range ≥1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  producer presents a beat.
- `in_ready`  out  1  unit can accept a beat this cycle.
- `op`  in  3  function select, sampled with the beat.
- `acc_mode`  in  1  beat uses the accumulator as operand B.
- `acc_clr`  in  1  clear/restart accumulator.
- `in1`  in  WIDTH  operand A.
- `in2`  in  WIDTH  operand B; ignored when `acc_mode`=1.
- `out_valid`  out  1  result register holds an unconsumed beat.
- `out_ready`  in  1  consumer accepts the result.
- `out`  out  WIDTH  registered result.
- `out_zero`, `out_parity`  out  1 each  present only with the macro described under Configuration.

## Operation
- Input transfer (xfer_in) = `in_valid` & `in_ready`. Output transfer (xfer_out) = `out_valid` & `out_ready`.
- op encoding, with B the effective operand:
  - 000 A&B; 001 A|B; 010 A^B; 011 ~(A&B)
  - 100 ~(A|B); 101 ~(A^B); 110 ~A; 111 A (pass)
- Ops 110/111 ignore B in all modes.
- Effective B:
  - `acc_mode`=0: B = `in2`.
  - `acc_mode`=1 and `acc_clr`=0: B = `acc`.
  - `acc_mode`=1 and `acc_clr`=1: B = 0. This starts a new reduction with the first word.
- Accumulator `acc` (WIDTH bits, internal) priority, evaluated each cycle:
  1. xfer_in with `acc_mode`=1: `acc` <= result. Applies to every op, including 110/111.
  2. Otherwise, `acc_clr`=1: `acc` <= 0.
  3. Otherwise: `acc` holds.
- An xfer_in with `acc_mode`=0 never modifies `acc`, unless `acc_clr` is also high, in which case rule 2 clears it.
- Result register:
  - On xfer_in: `out` <= result and `out_valid` <= 1.
  - Else on xfer_out: `out_valid` <= 0 and `out` holds its last value.
- `in_ready` = ~`out_valid` | `out_ready` (combinational). Full throughput: one beat per cycle when `out_ready` is held high.
- Simultaneous xfer_in and xfer_out: the new result replaces the old one and `out_valid` stays 1.
- All arithmetic is pure bitwise over WIDTH bits. There is no carry, and no truncation or extension.

## Timing
- Latency: a beat accepted at edge N appears on `out` with `out_valid`=1 after edge N.
- The `acc` updated at edge N is used as operand B by a beat accepted at edge N+1. Back-to-back accumulation therefore needs no bubbles.
- `in_ready` depends combinationally on `out_ready`. No other input-to-output combinational paths exist.
- Reset (async assert, sync-released deassert supplied externally):
  - `out_valid`=0, `out`=0, `acc`=0.
  - `out_zero`=1 and `out_parity`=0 when present.
  - `in_ready` reads 1 during reset.
- Reset mid-stream discards any held result and the accumulator. No beat is emitted after reset until a new xfer_in.
- While `out_valid`=1 and `out_ready`=0: `out` and the flags are stable, and `in_ready`=0.

## Configuration
- Macro `LOGIC_UNIT_PIPE_FLAGS_EN`.
- Defined:
  - Ports `out_zero` and `out_parity` exist.
  - Both are registered with `out` on xfer_in and hold otherwise.
  - `out_zero` = (result == 0). `out_parity` = XOR-reduce of result (1 = odd number of ones).
- Undefined: the ports and their registers are absent. All other behaviour is identical.

## Test plan
All scenarios use `WIDTH`=8.
- Basic ops, `out_ready`=1, `acc_mode`=0:
  - OR 0xA5,0x0F -> 0xAF
  - NAND 0xF0,0xFF -> 0x0F
  - XNOR 0xFF,0x0F -> 0x0F
  - NOT 0x3C -> 0xC3
  - Each appears one cycle after acceptance.
- Accumulate OR: back-to-back beats 0x01 (`acc_clr`=1), 0x10, 0x80 -> `out` sequence 0x01, 0x11, 0x91 on consecutive cycles. Then an XOR beat 0xFF with `acc_mode`=1 -> 0x6E.
- Backpressure:
  - Accept 0x11 with `out_ready`=0 -> `in_ready`=0 and `out` holds 0x11 for 5 cycles while `in_valid` stays high with 0x22.
  - Raise `out_ready` -> 0x11 is consumed and 0x22 is accepted in the same cycle. 0x22 appears next cycle with no bubble.
- Clear without beat: after accumulating 0x91, pulse `acc_clr` with `in_valid`=0. Then accumulate OR 0x04 -> `out`=0x04.
- Reset mid-stream: assert `rst_n`=0 asynchronously while `out_valid`=1 and `acc`=0x91 -> `out_valid`=0 and `out`=0 immediately. After release, accumulate OR 0x02 without `acc_clr` -> 0x02.
- With `LOGIC_UNIT_PIPE_FLAGS_EN`:
  - XOR 0x3C,0x3C -> `out`=0x00, `out_zero`=1, `out_parity`=0.
  - PASS 0x07 -> `out_zero`=0, `out_parity`=1.
  - Without the macro, the bench compiles with no flag ports.
